// File: rtl/msp430_pkg.sv
// msp430_pkg: shared fetch/decode types and constants for the MSP430 front end
package msp430_pkg;
    typedef enum logic [1:0] {FMT_I, FMT_II, FMT_JMP, FMT_ILL} fmt_t;
    typedef enum logic [2:0] {S_VEC, S_OP, S_SRC, S_DST, S_ISSUE, S_DRAIN} state_t;
    localparam logic [15:0] RST_VEC_DEF = 16'hFFFE;
    localparam logic [15:0] PC_STEP     = 16'd2;
    localparam logic [3:0]  PC_REG      = 4'd0;
    localparam logic [3:0]  CG1_REG     = 4'd2;
    localparam logic [3:0]  CG2_REG     = 4'd3;
endpackage

// File: rtl/instr_decode.sv
// instr_decode: combinational MSP430 format I/II/jump field decode and extension-word needs
module instr_decode
    import msp430_pkg::*;
(
    input  logic [15:0] i_ir,
    output fmt_t        o_fmt,
    output logic [3:0]  o_sa,
    output logic [3:0]  o_da,
    output logic [1:0]  o_as,
    output logic        o_ad,
    output logic        o_bw,
    output logic        o_need_src,
    output logic        o_need_dst
);
    logic w_f1, w_f2, w_jmp, w_cg;
    assign w_f1  = |i_ir[15:14];
    assign w_f2  = i_ir[15:10] == 6'b000100 && i_ir[9:7] != 3'b111;
    assign w_jmp = i_ir[15:13] == 3'b001;
    assign o_fmt = w_f1 ? FMT_I : w_f2 ? FMT_II : w_jmp ? FMT_JMP : FMT_ILL;
    assign o_sa  = w_f1 ? i_ir[11:8] : w_f2 ? i_ir[3:0] : 4'd0;
    assign o_da  = (w_f1 || w_f2) ? i_ir[3:0] : 4'd0;
    assign o_as  = (w_f1 || w_f2) ? i_ir[5:4] : 2'd0;
    assign o_bw  = (w_f1 || w_f2) && i_ir[6];
    assign o_ad  = w_f1 && i_ir[7];
    // constant generators synthesise their operand, so they never consume an extension word
    assign w_cg       = o_sa == CG2_REG || (o_sa == CG1_REG && o_as[1]);
    assign o_need_src = !w_cg && (o_as == 2'b01 || (o_as == 2'b11 && o_sa == PC_REG));
    assign o_need_dst = o_ad;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: MSP430 fetch/decode stage issuing decoded instructions over valid/ready
module instr_fetch
    import msp430_pkg::*;
#(
    parameter logic [15:0] RST_VEC_ADDR = RST_VEC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        issue_valid,
    input  logic        issue_ready,
    output logic [15:0] issue_ir,
    output logic [1:0]  issue_fmt,
    output logic [3:0]  issue_SA,
    output logic [3:0]  issue_DA,
    output logic [1:0]  issue_As,
    output logic        issue_Ad,
    output logic        issue_BW,
    output logic [15:0] issue_src_ext,
    output logic [15:0] issue_dst_ext,
    output logic [15:0] issue_pc,
    output logic [15:0] issue_next_pc
);
    state_t      r_state;
    fmt_t        r_fmt, w_fmt;
    logic        r_req, r_valid, r_ad, r_bw, r_need_dst;
    logic [15:0] r_addr, r_pc, r_ir, r_src, r_dst, r_ipc;
    logic [3:0]  r_sa, r_da, w_sa, w_da;
    logic [1:0]  r_as, w_as;
    logic        w_ad, w_bw, w_need_src, w_need_dst, w_ack, w_pending, w_more;
    logic [15:0] w_pc_inc, w_redir_pc;

    instr_decode u_dec (
        .i_ir       (mem_rdata),
        .o_fmt      (w_fmt),
        .o_sa       (w_sa),
        .o_da       (w_da),
        .o_as       (w_as),
        .o_ad       (w_ad),
        .o_bw       (w_bw),
        .o_need_src (w_need_src),
        .o_need_dst (w_need_dst)
    );

    assign w_ack      = r_req && mem_ack;
    assign w_pending  = r_req && !mem_ack;
    assign w_pc_inc   = r_pc + PC_STEP;
    assign w_redir_pc = redirect_pc & 16'hFFFE;
    assign w_more     = w_need_src || w_need_dst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_VEC;
            r_req      <= 1'b0;
            r_addr     <= '0;
            r_pc       <= '0;
            r_valid    <= 1'b0;
            r_ir       <= '0;
            r_fmt      <= FMT_I;
            r_sa       <= '0;
            r_da       <= '0;
            r_as       <= '0;
            r_ad       <= 1'b0;
            r_bw       <= 1'b0;
            r_src      <= '0;
            r_dst      <= '0;
            r_ipc      <= '0;
            r_need_dst <= 1'b0;
        end else if (redirect_valid && r_state != S_VEC) begin
            r_valid <= 1'b0;
            r_pc    <= w_redir_pc;
            // an in-flight read must still complete; its data is dropped in DRAIN
            if (w_pending) begin
                r_state <= S_DRAIN;
            end else begin
                r_state <= S_OP;
                r_req   <= 1'b1;
                r_addr  <= w_redir_pc;
            end
        end else begin
            case (r_state)
                S_VEC: begin
                    if (!r_req) begin
                        r_req  <= 1'b1;
                        r_addr <= RST_VEC_ADDR & 16'hFFFE;
                    end else if (mem_ack) begin
                        r_pc    <= mem_rdata & 16'hFFFE;
                        r_addr  <= mem_rdata & 16'hFFFE;
                        r_state <= S_OP;
                    end
                end
                S_OP: if (w_ack) begin
                    r_ir       <= mem_rdata;
                    r_ipc      <= r_pc;
                    r_fmt      <= w_fmt;
                    r_sa       <= w_sa;
                    r_da       <= w_da;
                    r_as       <= w_as;
                    r_ad       <= w_ad;
                    r_bw       <= w_bw;
                    r_src      <= '0;
                    r_dst      <= '0;
                    r_need_dst <= w_need_dst;
                    r_pc       <= w_pc_inc;
                    r_addr     <= w_pc_inc;
                    r_req      <= w_more;
                    r_valid    <= !w_more;
                    r_state    <= w_need_src ? S_SRC : w_need_dst ? S_DST : S_ISSUE;
                end
                S_SRC: if (w_ack) begin
                    r_src   <= mem_rdata;
                    r_pc    <= w_pc_inc;
                    r_addr  <= w_pc_inc;
                    r_req   <= r_need_dst;
                    r_valid <= !r_need_dst;
                    r_state <= r_need_dst ? S_DST : S_ISSUE;
                end
                S_DST: if (w_ack) begin
                    r_dst   <= mem_rdata;
                    r_pc    <= w_pc_inc;
                    r_addr  <= w_pc_inc;
                    r_req   <= 1'b0;
                    r_valid <= 1'b1;
                    r_state <= S_ISSUE;
                end
                S_ISSUE: if (issue_ready) begin
                    r_valid <= 1'b0;
                    r_req   <= 1'b1;
                    r_addr  <= r_pc;
                    r_state <= S_OP;
                end
                S_DRAIN: if (w_ack) begin
                    r_addr  <= r_pc;
                    r_state <= S_OP;
                end
                default: r_state <= S_VEC;
            endcase
        end
    end

    assign mem_req       = r_req;
    assign mem_addr      = r_addr;
    assign issue_valid   = r_valid;
    assign issue_ir      = r_ir;
    assign issue_fmt     = r_fmt;
    assign issue_SA      = r_sa;
    assign issue_DA      = r_da;
    assign issue_As      = r_as;
    assign issue_Ad      = r_ad;
    assign issue_BW      = r_bw;
    assign issue_src_ext = r_src;
    assign issue_dst_ext = r_dst;
    assign issue_pc      = r_ipc;
    assign issue_next_pc = r_pc;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized scoreboard bench for instr_fetch against a word-level ROM model
module tb_instr_fetch;
    typedef struct packed {
        logic [15:0] ir;
        logic [1:0]  fmt;
        logic [3:0]  sa;
        logic [3:0]  da;
        logic [1:0]  asm;
        logic        ad;
        logic        bw;
        logic [15:0] sx;
        logic [15:0] dx;
        logic [15:0] pc;
        logic [15:0] npc;
    } rec_t;

    logic        clk = 1'b0, rst = 1'b0;
    logic        mem_req, mem_ack;
    logic [15:0] mem_addr, mem_rdata;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        issue_valid, issue_ready = 1'b0;
    logic [15:0] issue_ir, issue_src_ext, issue_dst_ext, issue_pc, issue_next_pc;
    logic [1:0]  issue_fmt, issue_As;
    logic [3:0]  issue_SA, issue_DA;
    logic        issue_Ad, issue_BW;

    logic [15:0] rom [0:32767];
    rec_t        sb[$];
    logic [15:0] acks[$];
    rec_t        dut_rec;
    int          passed = 0, total = 0, popped = 0, target = 0;
    int          dly_fixed = -1, wait_cnt = 0, cnt_nxt = 0;
    logic        pend = 1'b0;
    logic [15:0] pend_addr = '0;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_ir(issue_ir), .issue_fmt(issue_fmt), .issue_SA(issue_SA), .issue_DA(issue_DA),
        .issue_As(issue_As), .issue_Ad(issue_Ad), .issue_BW(issue_BW),
        .issue_src_ext(issue_src_ext), .issue_dst_ext(issue_dst_ext),
        .issue_pc(issue_pc), .issue_next_pc(issue_next_pc)
    );

    assign dut_rec   = {issue_ir, issue_fmt, issue_SA, issue_DA, issue_As, issue_Ad, issue_BW,
                        issue_src_ext, issue_dst_ext, issue_pc, issue_next_pc};
    assign mem_ack   = mem_req && wait_cnt == 0;
    assign mem_rdata = rom[mem_addr[15:1]];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic int next_delay();
        return dly_fixed >= 0 ? dly_fixed : int'($urandom_range(0, 3));
    endfunction

    // Reference: decode by opcode value ranges and addressing-mode meaning
    function automatic rec_t model(input logic [15:0] pc);
        rec_t r;
        int ir;
        logic [15:0] p;
        r = '0;
        r.pc = pc;
        r.ir = rom[pc[15:1]];
        ir = int'(r.ir);
        p = pc + 16'd2;
        if (ir >= 'h4000) begin
            r.fmt = 2'd0;
            r.sa  = 4'((ir / 256) % 16);
            r.ad  = 1'((ir / 128) % 2);
            r.bw  = 1'((ir / 64) % 2);
            r.asm = 2'((ir / 16) % 4);
            r.da  = 4'(ir % 16);
        end else if (ir >= 'h2000) begin
            r.fmt = 2'd2;
        end else if (ir >= 'h1000 && ir < 'h1380) begin
            r.fmt = 2'd1;
            r.sa  = 4'(ir % 16);
            r.da  = r.sa;
            r.bw  = 1'((ir / 64) % 2);
            r.asm = 2'((ir / 16) % 4);
        end else begin
            r.fmt = 2'd3;
        end
        if (r.fmt < 2'd2 && ((r.asm == 2'd1 && r.sa != 4'd3) || (r.asm == 2'd3 && r.sa == 4'd0))) begin
            r.sx = rom[p[15:1]];
            p = p + 16'd2;
        end
        if (r.fmt == 2'd0 && r.ad) begin
            r.dx = rom[p[15:1]];
            p = p + 16'd2;
        end
        r.npc = p;
        return r;
    endfunction

    task automatic push_prog(input logic [15:0] start, input int k);
        logic [15:0] pc;
        rec_t r;
        pc = start;
        repeat (k) begin
            r = model(pc);
            sb.push_back(r);
            pc = r.npc;
        end
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!issue_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk({name, "_timeout"}, 128'(issue_valid), 128'(1));
    endtask

    task automatic stall_run(input int k, input string name);
        int n;
        wait_valid(name);
        repeat (5) begin
            chk({name, "_stall"}, 128'({issue_valid, mem_req, dut_rec}), 128'({1'b1, 1'b0, sb[0]}));
            @(negedge clk);
        end
        target += k;
        n = 0;
        while (popped < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_count"}, 128'(popped), 128'(target));
    endtask

    task automatic redirect(input logic [15:0] a);
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc = a;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (pend) chk("mem_hold", 128'({mem_req, mem_addr}), 128'({1'b1, pend_addr}));
        if (mem_req && mem_ack) begin
            acks.push_back(mem_addr);
            chk("addr_even", 128'(mem_addr[0]), 128'(0));
            cnt_nxt = next_delay();
        end else begin
            cnt_nxt = mem_req ? wait_cnt - 1 : wait_cnt;
        end
        pend = mem_req && !mem_ack;
        pend_addr = mem_addr;
    end

    always @(posedge clk) wait_cnt <= cnt_nxt;

    always @(negedge clk) begin
        if (rst && issue_valid && issue_ready) begin
            if (sb.size() == 0) chk("unexpected_issue", 128'(issue_valid), 128'(0));
            else chk("issue", 128'(dut_rec), 128'(sb.pop_front()));
            popped++;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        issue_ready = (popped < target) && ($urandom_range(0, 3) != 0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndr, n, k;
        logic [15:0] a;
        for (int i = 0; i < 32768; i++) rom[i] = 16'($urandom);
        rom[15'h7FFF] = 16'hC000;
        rom[15'h6000] = 16'h4596;
        rom[15'h6001] = 16'h1234;
        rom[15'h6002] = 16'h5678;
        rom[15'h6003] = 16'h4314;
        rom[15'h6004] = 16'h4034;
        rom[15'h6005] = 16'h0055;
        repeat (3) @(negedge clk);
        chk("rst_mem", 128'({mem_req, mem_addr}), 128'(0));
        chk("rst_issue", 128'({issue_valid, dut_rec}), 128'(0));
        push_prog(16'hC000, 6);
        @(posedge clk);
        #1;
        rst = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 16'h8000;
        @(posedge clk);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        stall_run(6, "boot");
        chk("vec_addr", 128'(acks[0]), 128'(16'hFFFE));
        chk("first_op_addr", 128'(acks[1]), 128'(16'hC000));

        wait_valid("idle_ill");
        rom[15'h5000] = 16'h0000;
        push_prog(16'hA000, 3);
        redirect(16'hA000);
        stall_run(3, "illegal");

        wait_valid("idle_wrap");
        rom[15'h7FFF] = 16'h3FFF;
        push_prog(16'hFFFE, 3);
        redirect(16'hFFFE);
        stall_run(3, "wrap");

        wait_valid("idle_drain");
        dly_fixed = 3;
        rom[15'h7000] = 16'h4596;
        rom[15'h7001] = 16'h1234;
        rom[15'h7002] = 16'h5678;
        redirect(16'hE000);
        n = 0;
        @(negedge clk);
        while (!(mem_req && !mem_ack && mem_addr == 16'hE002 && wait_cnt >= 2) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending_addr", 128'(mem_addr), 128'(16'hE002));
        ndr = acks.size();
        push_prog(16'hD000, 4);
        redirect_valid = 1'b1;
        redirect_pc = 16'hD001;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        dly_fixed = -1;
        stall_run(4, "drain");
        chk("drain_old_ack", 128'(acks[ndr]), 128'(16'hE002));
        chk("drain_new_ack", 128'(acks[ndr + 1]), 128'(16'hD000));

        repeat (6) begin
            wait_valid("idle_rand");
            a = 16'($urandom) & 16'hFFFE;
            k = int'($urandom_range(2, 6));
            push_prog(a, k);
            redirect(a);
            stall_run(k, "rand");
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
